// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST  = 32'h4000_0009;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Next-PC selection: redirect target or sequential PC, plus the +4 incrementer.
module if_pc_gen #(
  parameter int IM_ADDR_W = 14
) (
  input  logic [31:0]          pc_q,
  input  logic                 sel_redirect,
  input  logic [31:0]          redirect_pc,
  input  logic                 advance,
  output logic [31:0]          fetch_pc,
  output logic [31:0]          pc_d,
  output logic [IM_ADDR_W-1:0] fetch_addr
);
  import if_fetch_pkg::*;

  always_comb begin
    fetch_pc = sel_redirect ? word_align(redirect_pc) : pc_q;
    pc_d     = advance ? (fetch_pc + PC_STEP) : pc_q;
  end

  // Upper PC bits are simply dropped, so fetch wraps at the top of memory.
  assign fetch_addr = fetch_pc[IM_ADDR_W+1:2];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, IM request, response pairing, stall/redirect/halt.
// Optional FETCH_ALIGN_CHECK_EN flags misaligned redirect targets and halts.
module if_fetch #(
  parameter int          IM_ADDR_W = 14,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  input  logic                 halt_i,
  output logic                 IM_read,
  output logic [IM_ADDR_W-1:0] IM_addr,
  input  logic [31:0]          IM_out,
  output logic [31:0]          id_inst_o,
  output logic [31:0]          id_pc_o,
  output logic                 id_valid_o,
  output logic                 fetch_misalign_o
);
  import if_fetch_pkg::*;

  fetch_state_e          state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           rsp_pc_q, rsp_pc_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  misalign_q, misalign_d;

  logic                  take_redirect;
  logic                  advance;
  logic                  bad_align;
  logic [31:0]           fetch_pc;
  logic [IM_ADDR_W-1:0]  fetch_addr;

  always_comb begin
    take_redirect = redirect_i && (state_q != BOOT);
    advance       = take_redirect || ((state_q == RUN) && !halt_i && !stall_i);
`ifdef FETCH_ALIGN_CHECK_EN
    bad_align     = take_redirect && (redirect_pc_i[1:0] != 2'b00);
`else
    bad_align     = 1'b0;
`endif
  end

  if_pc_gen #(.IM_ADDR_W(IM_ADDR_W)) u_pc_gen (
    .pc_q         (pc_q),
    .sel_redirect (take_redirect),
    .redirect_pc  (redirect_pc_i),
    .advance      (advance),
    .fetch_pc     (fetch_pc),
    .pc_d         (pc_d),
    .fetch_addr   (fetch_addr)
  );

  always_comb begin
    state_d     = state_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = rsp_valid_q;
    misalign_d  = bad_align;
    if (advance) begin
      rsp_pc_d    = fetch_pc;
      rsp_valid_d = !bad_align;
    end
    unique case (state_q)
      BOOT: state_d = halt_i ? HALT : RUN;
      RUN: begin
        if (take_redirect) state_d = bad_align ? HALT : RUN;
        else if (halt_i)   state_d = HALT;
      end
      HALT: begin
        // The held instruction stays valid until decode takes it.
        if (take_redirect) state_d = bad_align ? HALT : RUN;
        else if (!stall_i) rsp_valid_d = 1'b0;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= ZERO_WORD;
      rsp_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
      misalign_q  <= misalign_d;
    end
  end

  always_comb begin
    IM_read          = advance;
    IM_addr          = (state_q == BOOT) ? '0 : fetch_addr;
    id_inst_o        = rsp_valid_q ? IM_out : NOP_INST;
    id_pc_o          = rsp_pc_q;
    id_valid_o       = rsp_valid_q;
    fetch_misalign_o = misalign_q;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then random traffic against a reference model.
`timescale 1ns/1ps
module tb_if_fetch;
  localparam int          IM_ADDR_W = 14;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h4000_0009;
  localparam logic [31:0] AMASK     = (32'd1 << IM_ADDR_W) - 32'd1;
  localparam int MB = 0, MR = 1, MH = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 stall_i, redirect_i, halt_i;
  logic [31:0]          redirect_pc_i;
  logic                 IM_read;
  logic [IM_ADDR_W-1:0] IM_addr;
  logic [31:0]          IM_out = 32'h0;
  logic [31:0]          id_inst_o, id_pc_o;
  logic                 id_valid_o, fetch_misalign_o;

  int checks = 0;
  int errors = 0;

  int          m_mode;
  logic [31:0] m_pc, m_rsp_pc, m_imout;
  logic        m_valid, m_mis;
  logic        e_read;
  logic [31:0] e_addr;

  if_fetch #(.IM_ADDR_W(IM_ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .halt_i(halt_i), .IM_read(IM_read),
    .IM_addr(IM_addr), .IM_out(IM_out), .id_inst_o(id_inst_o),
    .id_pc_o(id_pc_o), .id_valid_o(id_valid_o), .fetch_misalign_o(fetch_misalign_o)
  );

  always #5 clk = ~clk;

  // Instruction memory: word k holds k, one-cycle read, output holds when idle.
  always @(posedge clk) if (IM_read) IM_out <= 32'(IM_addr);

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MB; m_pc = RESET_PC; m_rsp_pc = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read"}, 32'(IM_read), 32'h0);
    chk({tag, "_addr"}, 32'(IM_addr), 32'h0);
    chk({tag, "_valid"}, 32'(id_valid_o), 32'h0);
    chk({tag, "_inst"}, id_inst_o, NOP);
    chk({tag, "_pc"}, id_pc_o, 32'h0);
    chk({tag, "_mis"}, 32'(fetch_misalign_o), 32'h0);
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic ht);
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc; halt_i = ht;
    @(negedge clk);
    e_read = 1'b0; e_addr = 32'h0;
    if (m_mode != MB && rd) begin
      e_read = 1'b1; e_addr = (rpc >> 2) & AMASK;
    end else if (m_mode == MR && !ht && !st) begin
      e_read = 1'b1; e_addr = (m_pc >> 2) & AMASK;
    end
    chk("im_read", 32'(IM_read), 32'(e_read));
    if (e_read) chk("im_addr", 32'(IM_addr), e_addr);
    chk("id_valid", 32'(id_valid_o), 32'(m_valid));
    chk("id_pc", id_pc_o, m_rsp_pc);
    chk("id_inst", id_inst_o, m_valid ? m_imout : NOP);
    chk("misalign", 32'(fetch_misalign_o), 32'(m_mis));
  endtask

  task automatic tick();
    logic [31:0] tgt;
    @(posedge clk);
    if (e_read) m_imout = e_addr;
    m_mis = 1'b0;
    if (m_mode == MB) begin
      m_mode = halt_i ? MH : MR;
    end else if (redirect_i) begin
      tgt = redirect_pc_i & ~32'h3;
      m_rsp_pc = tgt; m_pc = tgt + 32'd4; m_valid = 1'b1; m_mode = MR;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        m_valid = 1'b0; m_mis = 1'b1; m_mode = MH;
      end
`endif
    end else if (m_mode == MH) begin
      if (!stall_i) m_valid = 1'b0;
    end else if (halt_i) begin
      m_mode = MH;
    end else if (!stall_i) begin
      m_rsp_pc = m_pc; m_pc = m_pc + 32'd4; m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic ht);
    drive(st, rd, rpc, ht);
    tick();
  endtask

  initial begin
    int guard;
    logic [31:0] tgt;
    int r;
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0; redirect_pc_i = 32'h0;
    e_read = 1'b0; e_addr = 32'h0; m_imout = 32'h0;
    model_reset();
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Start-up: first valid instruction two cycles after release.
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("boot_valid", 32'(id_valid_o), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("first_valid", 32'(id_valid_o), 32'h1);
    chk("first_pc", id_pc_o, RESET_PC);
    chk("first_inst", id_inst_o, 32'h0);
    guard = 0;
    while (id_pc_o != 32'h8 && guard < 20) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      guard++;
    end
    chk("reach_pc8", id_pc_o, 32'h8);

    // Stall for three cycles holds word 2 / PC 8.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      chk("stall_read", 32'(IM_read), 32'h0);
      tick();
    end
    chk("stall_pc", id_pc_o, 32'h8);
    chk("stall_inst", id_inst_o, 32'h2);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("after_stall_pc", id_pc_o, 32'hC);

    // Redirect overrides stall with a same-cycle address bypass.
    drive(1'b1, 1'b1, 32'h40, 1'b0);
    chk("redir_addr", 32'(IM_addr), 32'h10);
    tick();
    chk("redir_pc", id_pc_o, 32'h40);
    chk("redir_valid", 32'(id_valid_o), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_next_pc", id_pc_o, 32'h44);

    // Halt at PC 0x10, then resume from 0 by redirect.
    step(1'b0, 1'b1, 32'h10, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("halt_pc", id_pc_o, 32'h10);
    chk("halt_valid", 32'(id_valid_o), 32'h1);
    tick();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("halted_read", 32'(IM_read), 32'h0);
    chk("halted_valid", 32'(id_valid_o), 32'h0);
    tick();
    step(1'b0, 1'b1, 32'h0, 1'b0);
    chk("resume_pc", id_pc_o, 32'h0);
    chk("resume_valid", 32'(id_valid_o), 32'h1);

    // Top of instruction memory wraps the word address.
    step(1'b0, 1'b1, 32'h0000_FFFC, 1'b0);
    chk("top_inst", id_inst_o, 32'h3FFF);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr", 32'(IM_addr), 32'h0);
    tick();
    chk("wrap_pc", id_pc_o, 32'h0001_0000);
    chk("wrap_inst", id_inst_o, 32'h0);

    // Misaligned redirect target.
    drive(1'b0, 1'b1, 32'h42, 1'b0);
    chk("mis_addr", 32'(IM_addr), 32'h10);
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_pulse", 32'(fetch_misalign_o), 32'h1);
    chk("mis_valid", 32'(id_valid_o), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis_pulse_end", 32'(fetch_misalign_o), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis_halt_read", 32'(IM_read), 32'h0);
    tick();
    step(1'b0, 1'b1, 32'h100, 1'b0);
`else
    chk("mis_pc", id_pc_o, 32'h40);
    chk("mis_inst", id_inst_o, 32'h10);
    chk("mis_flag", 32'(fetch_misalign_o), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis_next_pc", id_pc_o, 32'h44);
`endif

    // Asynchronous reset in the middle of a stalled redirect.
    step(1'b0, 1'b1, 32'h100, 1'b0);
    drive(1'b1, 1'b1, 32'h200, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0; e_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 9) == 0) tgt = 32'h0000_FFF0 + (32'($urandom_range(0, 3)) << 2);
      else                           tgt = 32'($urandom_range(0, 4095)) << 2;
      if ($urandom_range(0, 5) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      step(($urandom_range(0, 3) == 0), (r < 8), tgt, (r >= 8 && r < 11));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage pipeline. Holds the program counter and drives the synchronous-read instruction memory (one-cycle read latency; output register holds when not read). Pairs each returned word with the PC that requested it and presents the pair to the decode stage. Handles decode-stage stall, execute-stage redirect (branch/jump) and halt.

## Interface
Parameters:
- IM_ADDR_W, 14, width of the instruction-memory word address (memory depth 2^IM_ADDR_W words).
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- stall_i  input  1  decode stage cannot accept a new instruction this cycle.
- redirect_i  input  1  redirect fetch to redirect_pc_i (taken branch/jump from EX).
- redirect_pc_i  input  32  byte target address.
- halt_i  input  1  stop fetching; sticky until the next redirect.
- IM_read  output  1  read enable to instruction memory.
- IM_addr  output  IM_ADDR_W  word address to instruction memory.
- IM_out  input  32  instruction word, valid the cycle after an accepted read.
- id_inst_o  output  32  instruction to decode; NOP_INST when id_valid_o=0.
- id_pc_o  output  32  byte PC of id_inst_o.
- id_valid_o  output  1  id_inst_o is a real fetched instruction.
- fetch_misalign_o  output  1  redirect target not word-aligned (see Configuration).

## Operation
- State register: BOOT, RUN, HALT.
- Registers: pc_q (next byte address to request), rsp_pc_q (PC of the word in IM_out), rsp_valid_q.
- BOOT: entered on reset. IM_read=0, id_valid_o=0. Moves to RUN after one cycle, or directly to HALT if halt_i is high.
- RUN, priority redirect > halt > stall > normal:
  - redirect_i: IM_read=1, IM_addr=redirect_pc_i[IM_ADDR_W+1:2] (combinational bypass). pc_q<=redirect_pc_i+4, rsp_pc_q<=redirect_pc_i, rsp_valid_q<=1. The word in IM_out is wrong-path and replaced next cycle. Redirect overrides stall.
  - halt_i: IM_read=0. Go to HALT. rsp_valid_q unchanged, so the current instruction is still delivered.
  - stall_i: IM_read=0. All registers hold. IM_out holds, so the decode output is stable.
  - normal: IM_read=1, IM_addr=pc_q[IM_ADDR_W+1:2], pc_q<=pc_q+4, rsp_pc_q<=pc_q, rsp_valid_q<=1.
- HALT: IM_read=0. Once the held instruction is consumed (a cycle with stall_i=0), rsp_valid_q<=0. redirect_i behaves as in RUN and returns to RUN.
- Outputs:
  - id_inst_o = rsp_valid_q ? IM_out : NOP_INST.
  - id_pc_o = rsp_pc_q.
  - id_valid_o = rsp_valid_q.
- Arithmetic: pc_q+4 wraps modulo 2^32. IM_addr truncates, so fetch wraps at the top of instruction memory with no error.

## Timing
- Reset values: pc_q=RESET_PC, rsp_pc_q=0, rsp_valid_q=0, state BOOT. Outputs: IM_read=0, IM_addr=0, id_valid_o=0, id_inst_o=NOP_INST, fetch_misalign_o=0.
- Fetch latency is 1 cycle: request at edge n gives instruction at decode after edge n+1. Steady state delivers one instruction per cycle.
- First valid instruction (RESET_PC) appears at decode 2 cycles after reset release.
- Redirect penalty: exactly one wrong-path slot; the target instruction is at decode the cycle after redirect_i.
- Reset asserted mid-operation: immediately returns to the reset values, regardless of stall or redirect.
- IM_read, IM_addr and id_* are driven combinationally from state, registers and the redirect/stall inputs. There is no combinational path from IM_out to IM_addr.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: when redirect_pc_i[1:0]!=0, the redirect is taken but rsp_valid_q<=0 and fetch_misalign_o is pulsed high for 1 cycle. The state moves to HALT until the next aligned redirect.
- Not defined: fetch_misalign_o is tied 0 and the low two address bits are ignored (silently aligned down).

## Structure
- Shared package: fetch_state_e (BOOT, RUN, HALT), NOP_INST = 32'h4000_0009, ZERO_WORD, PC_STEP = 4.
- One natural sub-module, if_pc_gen: next-PC mux plus the +4 incrementer.
- FSM and response registers live in if_fetch.

## Test plan
- Reset release, no stall, memory word k = k: IM_addr 0,1,2… from cycle 1. id_inst_o = 0,1,2… with id_pc_o = 0,4,8…, first valid 2 cycles after release.
- stall_i high for 3 cycles while id_pc_o=8: IM_read=0, id_inst_o/id_pc_o held at word 2 / 8. After release, next delivered is PC 12.
- redirect_i with redirect_pc_i=0x40 while stall_i=1: IM_addr=0x10 in the same cycle. Next cycle id_pc_o=0x40, id_valid_o=1. Following cycle PC 0x44.
- halt_i pulse at PC 0x10: 0x10 delivered, then id_valid_o=0 and IM_read=0 indefinitely. A redirect to 0 resumes at PC 0.
- pc_q = 4·(2^IM_ADDR_W−1): next IM_addr=0 with id_pc_o=4·2^IM_ADDR_W (no stall, no error).
- With FETCH_ALIGN_CHECK_EN, redirect to 0x42: fetch_misalign_o=1 for 1 cycle, id_valid_o=0, then HALT. Without the macro: fetch resumes at 0x40.
